water_valve_controller: RTL and testbench
=========================================

WATER_VALVE_CONTROLLER -- requirements
Module: water_valve_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 200, max cycles the timeout counter may count in FILL/DRAIN before fault.
REQ-002 Parameter SETTLE_CYCLES, default 4, valve-off cycles before re-checking level.
REQ-003 Parameter HYSTERESIS, default 5, allowed shortfall from target_level, in level units.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request; sampled only in IDLE.
REQ-007 mode  in  1  1 = fill, 0 = drain; latched with start.
REQ-008 target_level  in  10  unsigned target; latched with start.
REQ-009 water_level_sensor  in  10  unsigned current level, same encoding the flow monitor consumes.
REQ-010 flow_error  in  1  error_flag from the flow monitor.
REQ-011 abort  in  1  return to IDLE from any state.
REQ-012 inlet_valve  out  1  registered fill valve command.
REQ-013 drain_pump  out  1  registered drain pump command.
REQ-014 busy  out  1  high in FILL, DRAIN, SETTLE.
REQ-015 done  out  1  one-cycle success pulse.
REQ-016 fault  out  1  sticky failure flag.

Function
REQ-017 The FSM SHALL have states IDLE, FILL, DRAIN, SETTLE, DONE, FAULT.
REQ-018 In IDLE with start=1, the block SHALL latch mode and target_level, clear the timeout counter, and next cycle enter DONE if already satisfied (fill: level>=target; drain: level<=target); otherwise enter FILL (mode=1) or DRAIN (mode=0).
REQ-019 inlet_valve SHALL be 1 exactly in FILL cycles, and drain_pump exactly in DRAIN cycles; both SHALL never be 1 together.
REQ-020 FILL SHALL exit to SETTLE on the first cycle level>=latched target; DRAIN on the first cycle level<=latched target.
REQ-021 The timeout counter SHALL increment every FILL/DRAIN cycle, SHALL NOT reset on SETTLE re-entry, and on reaching TIMEOUT_CYCLES-1 SHALL force FAULT next cycle.
REQ-022 flow_error=1 in FILL or DRAIN SHALL force FAULT next cycle; it SHALL take priority over target reached and timeout.
REQ-023 SETTLE SHALL hold both actuators off for SETTLE_CYCLES cycles, then: fill with level+HYSTERESIS<target, re-enter FILL; drain with level>target+HYSTERESIS, re-enter DRAIN; otherwise DONE.
REQ-024 Level comparisons with HYSTERESIS SHALL use 11-bit arithmetic, so no overflow at 1023.
REQ-025 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-026 FAULT SHALL hold fault=1 with both actuators off until reset or abort.
REQ-027 abort=1 SHALL move any state to IDLE next cycle, turn off both actuators and clear fault; abort overrides start in the same cycle.
REQ-028 start outside IDLE SHALL be ignored; latched mode/target SHALL NOT change mid-operation.

Reset
REQ-029 On reset=1 at a clock edge: state=IDLE, inlet_valve=0, drain_pump=0, busy=0, done=0, fault=0, counters=0, latched target=0, latched mode=1.
REQ-030 Reset SHALL take priority over abort, start and flow_error, including mid-FILL/DRAIN.

Structure
REQ-031 The state encoding and default parameter values SHALL live in the shared washing-machine package, shared with the flow monitor.
REQ-032 The settle and timeout counting MAY be a single sub-module, valve_cycle_counter (load, enable, terminal-count output); all other logic stays in this module.

Verification
REQ-033 Fill: start, mode=1, target=150, level 50 rising by 20 every 2 cycles -> inlet_valve high until level>=150, SETTLE for 4 cycles, done pulse, fault=0.
REQ-034 Drain: start, mode=0, target=40, level 200 falling by 20 every 2 cycles -> drain_pump only, then done; inlet_valve never high.
REQ-035 Stall: fill target=300, level held at 100, TIMEOUT_CYCLES=20 -> fault=1 after 20 FILL cycles, valve off, stays set until abort.
REQ-036 flow_error pulsed mid-DRAIN -> FAULT next cycle, drain_pump=0 the same cycle fault rises.
REQ-037 Overshoot/retry: fill target=100, level drops to 90 during SETTLE -> re-enter FILL; at level 96 -> DONE (within HYSTERESIS=5).
REQ-038 Boundaries: start with level already at target -> DONE without actuation; reset asserted mid-FILL -> all outputs 0 next cycle; target=1023 fill -> no overflow, timeout FAULT.

Source files
------------

// File: rtl/washing_machine_pkg.sv
// Shared washing-machine definitions: valve controller state encoding and default timing.
// The flow monitor imports the same level width so sensor encodings stay aligned.
package washing_machine_pkg;

    localparam int LEVEL_W                = 10;
    localparam int DEFAULT_TIMEOUT_CYCLES = 200;
    localparam int DEFAULT_SETTLE_CYCLES  = 4;
    localparam int DEFAULT_HYSTERESIS     = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4,
        ST_FAULT  = 3'd5
    } valve_state_t;

endpackage

// File: rtl/valve_cycle_counter.sv
// Up-counter with synchronous clear; tc is high while the count sits at TERMINAL-1.
// Used for both the settle delay and the fill/drain timeout.
module valve_cycle_counter #(
    parameter int TERMINAL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic tc
);

    localparam int CNT_W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == CNT_W'(TERMINAL - 1));

endmodule

// File: rtl/water_valve_controller.sv
// Fill/drain sequencer driving the inlet valve and drain pump toward a latched target level,
// with post-actuation settling, hysteresis re-check, timeout and flow-error fault handling.
module water_valve_controller
    import washing_machine_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int SETTLE_CYCLES  = DEFAULT_SETTLE_CYCLES,
    parameter int HYSTERESIS     = DEFAULT_HYSTERESIS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic [LEVEL_W-1:0] target_level,
    input  logic [LEVEL_W-1:0] water_level_sensor,
    input  logic               flow_error,
    input  logic               abort,
    output logic               inlet_valve,
    output logic               drain_pump,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output valve_state_t       state_dbg
);

    valve_state_t       state, next_state;
    logic               mode_q, mode_d;
    logic [LEVEL_W-1:0] target_q, target_d;
    logic               to_load, to_en, to_tc;
    logic               st_load, st_en, st_tc;

    // One spare bit keeps level +/- hysteresis sums exact up to full scale.
    logic [LEVEL_W:0] level_x, target_x, hyst_x;
    logic             fill_reached, drain_reached, start_satisfied;

    assign level_x         = {1'b0, water_level_sensor};
    assign target_x        = {1'b0, target_q};
    assign hyst_x          = (LEVEL_W + 1)'(HYSTERESIS);
    assign fill_reached    = (water_level_sensor >= target_q);
    assign drain_reached   = (water_level_sensor <= target_q);
    assign start_satisfied = mode ? (water_level_sensor >= target_level)
                                  : (water_level_sensor <= target_level);

    valve_cycle_counter #(.TERMINAL(TIMEOUT_CYCLES)) u_timeout (
        .clk(clk), .reset(reset), .load(to_load), .enable(to_en), .tc(to_tc)
    );

    valve_cycle_counter #(.TERMINAL(SETTLE_CYCLES)) u_settle (
        .clk(clk), .reset(reset), .load(st_load), .enable(st_en), .tc(st_tc)
    );

    // start is a single-cycle request with no ready: it is only looked at in IDLE,
    // and every other state drops it silently. abort wins over start in the same cycle.
    always_comb begin
        next_state = state;
        mode_d     = mode_q;
        target_d   = target_q;
        to_load    = 1'b0;
        to_en      = 1'b0;
        st_load    = 1'b0;
        st_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    target_d   = target_level;
                    to_load    = 1'b1;
                    next_state = start_satisfied ? ST_DONE : (mode ? ST_FILL : ST_DRAIN);
                end
            end
            ST_FILL, ST_DRAIN: begin
                to_en = 1'b1;
                if (flow_error) begin
                    next_state = ST_FAULT;
                end else if ((state == ST_FILL) ? fill_reached : drain_reached) begin
                    next_state = ST_SETTLE;
                    st_load    = 1'b1;
                end else if (to_tc) begin
                    next_state = ST_FAULT;
                end
            end
            ST_SETTLE: begin
                st_en = 1'b1;
                if (st_tc) begin
                    if (mode_q && (level_x + hyst_x < target_x)) begin
                        next_state = ST_FILL;
                    end else if (!mode_q && (level_x > target_x + hyst_x)) begin
                        next_state = ST_DRAIN;
                    end else begin
                        next_state = ST_DONE;
                    end
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            ST_FAULT: next_state = ST_FAULT;
            default:  next_state = ST_IDLE;
        endcase
        if (abort) begin
            next_state = ST_IDLE;
            mode_d     = mode_q;
            target_d   = target_q;
        end
    end

    // Outputs are registered straight from next_state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            mode_q      <= 1'b1;
            target_q    <= '0;
            inlet_valve <= 1'b0;
            drain_pump  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= next_state;
            mode_q      <= mode_d;
            target_q    <= target_d;
            inlet_valve <= (next_state == ST_FILL);
            drain_pump  <= (next_state == ST_DRAIN);
            busy        <= (next_state == ST_FILL) || (next_state == ST_DRAIN) ||
                           (next_state == ST_SETTLE);
            done        <= (next_state == ST_DONE);
            fault       <= (next_state == ST_FAULT);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_water_valve_controller.sv
// Directed bench for water_valve_controller: fill, drain, stall timeout, flow error,
// settle retry, already-at-target, reset mid-fill and full-scale target cases.
module tb_water_valve_controller;
    import washing_machine_pkg::*;

    logic         clk = 1'b0;
    logic         reset, start, mode, flow_error, abort;
    logic [9:0]   target_level, water_level_sensor;
    logic         inlet_valve, drain_pump, busy, done, fault;
    valve_state_t state_dbg;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    water_valve_controller #(
        .TIMEOUT_CYCLES(20),
        .SETTLE_CYCLES (4),
        .HYSTERESIS    (5)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .mode              (mode),
        .target_level      (target_level),
        .water_level_sensor(water_level_sensor),
        .flow_error        (flow_error),
        .abort             (abort),
        .inlet_valve       (inlet_valve),
        .drain_pump        (drain_pump),
        .busy              (busy),
        .done              (done),
        .fault             (fault),
        .state_dbg         (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // exp bits: {inlet_valve, drain_pump, busy, done, fault}
    task automatic check_outs(input string tag, input logic [4:0] exp, input valve_state_t st);
        check($sformatf("%s.inlet", tag), 32'(inlet_valve), 32'(exp[4]));
        check($sformatf("%s.drain", tag), 32'(drain_pump),  32'(exp[3]));
        check($sformatf("%s.busy",  tag), 32'(busy),        32'(exp[2]));
        check($sformatf("%s.done",  tag), 32'(done),        32'(exp[1]));
        check($sformatf("%s.fault", tag), 32'(fault),       32'(exp[0]));
        check($sformatf("%s.state", tag), 32'(state_dbg),   32'(st));
    endtask

    task automatic do_start(input logic m, input logic [9:0] tgt);
        start        = 1'b1;
        mode         = m;
        target_level = tgt;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; flow_error = 1'b0; abort = 1'b0;
        target_level = 10'd0; water_level_sensor = 10'd0;
        tick();
        tick();
        check_outs("reset", 5'b00000, ST_IDLE);
        reset = 1'b0;

        // abort and start together: stay idle
        water_level_sensor = 10'd50;
        start = 1'b1; mode = 1'b1; target_level = 10'd150; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_outs("abort_over_start", 5'b00000, ST_IDLE);

        // fill 50 -> 150, +20 every 2 cycles
        do_start(1'b1, 10'd150);
        check_outs("fill_enter", 5'b10100, ST_FILL);
        while (water_level_sensor < 10'd150) begin
            repeat (2) begin
                tick();
                check_outs("fill_run", 5'b10100, ST_FILL);
            end
            water_level_sensor = water_level_sensor + 10'd20;
        end
        tick();
        check_outs("fill_settle", 5'b00100, ST_SETTLE);
        repeat (3) begin
            tick();
            check_outs("fill_settle_hold", 5'b00100, ST_SETTLE);
        end
        tick();
        check_outs("fill_done", 5'b00010, ST_DONE);
        tick();
        check_outs("fill_idle", 5'b00000, ST_IDLE);

        // drain 200 -> 40, -20 every 2 cycles; a mid-drain start must be ignored
        water_level_sensor = 10'd200;
        do_start(1'b0, 10'd40);
        check_outs("drain_enter", 5'b01100, ST_DRAIN);
        start = 1'b1; mode = 1'b1; target_level = 10'd1000;
        tick();
        start = 1'b0;
        check_outs("drain_ignore_start", 5'b01100, ST_DRAIN);
        while (water_level_sensor > 10'd40) begin
            repeat (2) begin
                tick();
                check_outs("drain_run", 5'b01100, ST_DRAIN);
            end
            water_level_sensor = water_level_sensor - 10'd20;
        end
        tick();
        check_outs("drain_settle", 5'b00100, ST_SETTLE);
        repeat (3) begin
            tick();
            check_outs("drain_settle_hold", 5'b00100, ST_SETTLE);
        end
        tick();
        check_outs("drain_done", 5'b00010, ST_DONE);
        tick();
        check_outs("drain_idle", 5'b00000, ST_IDLE);

        // stall: 20 FILL cycles then FAULT, sticky until abort
        water_level_sensor = 10'd100;
        do_start(1'b1, 10'd300);
        check_outs("stall_enter", 5'b10100, ST_FILL);
        repeat (19) begin
            tick();
            check_outs("stall_fill", 5'b10100, ST_FILL);
        end
        tick();
        check_outs("stall_fault", 5'b00001, ST_FAULT);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_outs("stall_fault_start", 5'b00001, ST_FAULT);
        repeat (2) begin
            tick();
            check_outs("stall_fault_hold", 5'b00001, ST_FAULT);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_outs("stall_abort", 5'b00000, ST_IDLE);

        // flow_error mid-drain
        water_level_sensor = 10'd200;
        do_start(1'b0, 10'd40);
        check_outs("flow_enter", 5'b01100, ST_DRAIN);
        tick();
        check_outs("flow_drain", 5'b01100, ST_DRAIN);
        flow_error = 1'b1;
        tick();
        flow_error = 1'b0;
        check_outs("flow_fault", 5'b00001, ST_FAULT);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_outs("flow_abort", 5'b00000, ST_IDLE);

        // settle drop to 90 -> refill; settle at 96 -> done
        water_level_sensor = 10'd80;
        do_start(1'b1, 10'd100);
        check_outs("retry_enter", 5'b10100, ST_FILL);
        water_level_sensor = 10'd100;
        tick();
        check_outs("retry_settle1", 5'b00100, ST_SETTLE);
        water_level_sensor = 10'd90;
        repeat (3) begin
            tick();
            check_outs("retry_settle1_hold", 5'b00100, ST_SETTLE);
        end
        tick();
        check_outs("retry_refill", 5'b10100, ST_FILL);
        water_level_sensor = 10'd100;
        tick();
        check_outs("retry_settle2", 5'b00100, ST_SETTLE);
        water_level_sensor = 10'd96;
        repeat (3) begin
            tick();
            check_outs("retry_settle2_hold", 5'b00100, ST_SETTLE);
        end
        tick();
        check_outs("retry_done", 5'b00010, ST_DONE);
        tick();
        check_outs("retry_idle", 5'b00000, ST_IDLE);

        // already at target: straight to DONE, no actuation
        water_level_sensor = 10'd150;
        do_start(1'b1, 10'd150);
        check_outs("at_target_fill", 5'b00010, ST_DONE);
        tick();
        check_outs("at_target_fill_idle", 5'b00000, ST_IDLE);
        water_level_sensor = 10'd40;
        do_start(1'b0, 10'd40);
        check_outs("at_target_drain", 5'b00010, ST_DONE);
        tick();
        check_outs("at_target_drain_idle", 5'b00000, ST_IDLE);

        // reset mid-fill beats abort/start/flow_error
        water_level_sensor = 10'd0;
        do_start(1'b1, 10'd500);
        check_outs("rst_fill", 5'b10100, ST_FILL);
        tick();
        check_outs("rst_fill2", 5'b10100, ST_FILL);
        reset = 1'b1; abort = 1'b1; start = 1'b1; flow_error = 1'b1;
        tick();
        check_outs("rst_mid_fill", 5'b00000, ST_IDLE);
        reset = 1'b0; abort = 1'b0; start = 1'b0; flow_error = 1'b0;
        tick();
        check_outs("rst_after", 5'b00000, ST_IDLE);

        // full-scale target: settle check at 1020 must not wrap
        water_level_sensor = 10'd1000;
        do_start(1'b1, 10'd1023);
        check_outs("top_enter", 5'b10100, ST_FILL);
        water_level_sensor = 10'd1023;
        tick();
        check_outs("top_settle", 5'b00100, ST_SETTLE);
        water_level_sensor = 10'd1020;
        repeat (3) begin
            tick();
            check_outs("top_settle_hold", 5'b00100, ST_SETTLE);
        end
        tick();
        check_outs("top_done", 5'b00010, ST_DONE);
        tick();
        check_outs("top_idle", 5'b00000, ST_IDLE);

        // full-scale target never reached: timeout fault
        water_level_sensor = 10'd1020;
        do_start(1'b1, 10'd1023);
        check_outs("top_stall_enter", 5'b10100, ST_FILL);
        repeat (19) begin
            tick();
            check_outs("top_stall_fill", 5'b10100, ST_FILL);
        end
        tick();
        check_outs("top_stall_fault", 5'b00001, ST_FAULT);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_outs("top_stall_abort", 5'b00000, ST_IDLE);

        if (fail_cnt != 0) $display("%0d comparisons did not match", fail_cnt);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
